// File: rtl/vx_tex_agent.sv
// vx_tex_agent: issues tex requests tagged {uuid,slot} from a pending table and
// turns tex responses into registered writeback commits using the stored slot metadata.
module vx_tex_agent #(
   parameter int NUM_LANES    = 4,
   parameter int NUM_WARPS    = 4,
   parameter int PENDING_SIZE = 8,
   parameter int UUID_WIDTH   = 44,
   parameter int LOD_BITS     = 4,
   parameter int STAGE_BITS   = 1,
   localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int SLOT_BITS   = $clog2(PENDING_SIZE),
   localparam int TAG_WIDTH   = UUID_WIDTH + SLOT_BITS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          exe_valid,
   input  logic [UUID_WIDTH-1:0]         exe_uuid,
   input  logic [NW_BITS-1:0]            exe_wid,
   input  logic [NUM_LANES-1:0]          exe_tmask,
   input  logic [31:0]                   exe_pc,
   input  logic [4:0]                    exe_rd,
   input  logic [2*NUM_LANES*32-1:0]     exe_coords,
   input  logic [NUM_LANES*LOD_BITS-1:0] exe_lod,
   input  logic [STAGE_BITS-1:0]         exe_stage,
   output logic                          exe_ready,
   output logic                          tex_req_valid,
   output logic [NUM_LANES-1:0]          tex_req_mask,
   output logic [2*NUM_LANES*32-1:0]     tex_req_coords,
   output logic [NUM_LANES*LOD_BITS-1:0] tex_req_lod,
   output logic [STAGE_BITS-1:0]         tex_req_stage,
   output logic [TAG_WIDTH-1:0]          tex_req_tag,
   input  logic                          tex_req_ready,
   input  logic                          tex_rsp_valid,
   input  logic [NUM_LANES*32-1:0]       tex_rsp_texels,
   input  logic [TAG_WIDTH-1:0]          tex_rsp_tag,
   output logic                          tex_rsp_ready,
   output logic                          commit_valid,
   output logic [UUID_WIDTH-1:0]         commit_uuid,
   output logic [NW_BITS-1:0]            commit_wid,
   output logic [NUM_LANES-1:0]          commit_tmask,
   output logic [31:0]                   commit_pc,
   output logic [4:0]                    commit_rd,
   output logic [NUM_LANES*32-1:0]       commit_data,
   input  logic                          commit_ready,
   output logic [SLOT_BITS:0]            pending_count
);
   logic [PENDING_SIZE-1:0] busy;
   logic [UUID_WIDTH-1:0]   t_uuid  [PENDING_SIZE];
   logic [NW_BITS-1:0]      t_wid   [PENDING_SIZE];
   logic [NUM_LANES-1:0]    t_tmask [PENDING_SIZE];
   logic [31:0]             t_pc    [PENDING_SIZE];
   logic [4:0]              t_rd    [PENDING_SIZE];
   logic                    full, exe_fire, rsp_fire;
   logic [SLOT_BITS-1:0]    aslot, rslot;
   logic [NUM_LANES*32-1:0] masked;

   assign full          = &busy;
   assign exe_ready     = ~reset & ~full & (~tex_req_valid | tex_req_ready);
   assign exe_fire      = exe_valid & exe_ready;
   assign tex_rsp_ready = ~commit_valid | commit_ready;
   assign rsp_fire      = tex_rsp_valid & tex_rsp_ready;
   assign rslot         = tex_rsp_tag[SLOT_BITS-1:0];

   // descending scan so the lowest free index wins
   always_comb begin
      aslot = '0;
      for (int i = PENDING_SIZE - 1; i >= 0; i--)
         if (!busy[i]) aslot = SLOT_BITS'(i);
   end

   always_comb begin
      masked = '0;
      for (int i = 0; i < NUM_LANES; i++)
         masked[i*32 +: 32] = t_tmask[rslot][i] ? tex_rsp_texels[i*32 +: 32] : 32'd0;
   end

   // alloc and free never hit the same slot: the freed slot is still busy pre-edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy          <= '0;
         pending_count <= '0;
         for (int i = 0; i < PENDING_SIZE; i++) begin
            t_uuid[i]  <= '0;
            t_wid[i]   <= '0;
            t_tmask[i] <= '0;
            t_pc[i]    <= '0;
            t_rd[i]    <= '0;
         end
      end else begin
         if (exe_fire) begin
            t_uuid[aslot]  <= exe_uuid;
            t_wid[aslot]   <= exe_wid;
            t_tmask[aslot] <= exe_tmask;
            t_pc[aslot]    <= exe_pc;
            t_rd[aslot]    <= exe_rd;
         end
         busy          <= (busy & ~(PENDING_SIZE'(rsp_fire) << rslot)) | (PENDING_SIZE'(exe_fire) << aslot);
         pending_count <= pending_count + (SLOT_BITS+1)'(exe_fire) - (SLOT_BITS+1)'(rsp_fire);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tex_req_valid  <= 1'b0;
         tex_req_mask   <= '0;
         tex_req_coords <= '0;
         tex_req_lod    <= '0;
         tex_req_stage  <= '0;
         tex_req_tag    <= '0;
      end else if (exe_fire) begin
         tex_req_valid  <= 1'b1;
         tex_req_mask   <= exe_tmask;
         tex_req_coords <= exe_coords;
         tex_req_lod    <= exe_lod;
         tex_req_stage  <= exe_stage;
         tex_req_tag    <= {exe_uuid, aslot};
      end else if (tex_req_ready) begin
         tex_req_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         commit_valid <= 1'b0;
         commit_uuid  <= '0;
         commit_wid   <= '0;
         commit_tmask <= '0;
         commit_pc    <= '0;
         commit_rd    <= '0;
         commit_data  <= '0;
      end else if (rsp_fire) begin
         commit_valid <= 1'b1;
         commit_uuid  <= t_uuid[rslot];
         commit_wid   <= t_wid[rslot];
         commit_tmask <= t_tmask[rslot];
         commit_pc    <= t_pc[rslot];
         commit_rd    <= t_rd[rslot];
         commit_data  <= masked;
      end else if (commit_ready) begin
         commit_valid <= 1'b0;
      end
   end

   a_rsp_busy: assert property (@(posedge clk) disable iff (reset) rsp_fire |-> busy[rslot]);
   a_rsp_uuid: assert property (@(posedge clk) disable iff (reset)
      rsp_fire |-> tex_rsp_tag[TAG_WIDTH-1:SLOT_BITS] == t_uuid[rslot]);
   a_no_full_issue: assert property (@(posedge clk) disable iff (reset) exe_fire |-> !full);
endmodule

// File: tb/tb_vx_tex_agent.sv
// tb_vx_tex_agent: directed and randomized checks of vx_tex_agent against a
// slot-table model (lowest-free allocation, per-lane masking of texels).
module tb_vx_tex_agent;
   logic         clk = 1'b0, reset = 1'b1;
   logic         exe_valid = 1'b0, exe_ready;
   logic [43:0]  exe_uuid = '0;
   logic [1:0]   exe_wid = '0;
   logic [3:0]   exe_tmask = '0;
   logic [31:0]  exe_pc = '0;
   logic [4:0]   exe_rd = '0;
   logic [255:0] exe_coords = '0;
   logic [15:0]  exe_lod = '0;
   logic [0:0]   exe_stage = '0;
   logic         tex_req_valid, tex_req_ready = 1'b1;
   logic [3:0]   tex_req_mask;
   logic [255:0] tex_req_coords;
   logic [15:0]  tex_req_lod;
   logic [0:0]   tex_req_stage;
   logic [46:0]  tex_req_tag;
   logic         tex_rsp_valid = 1'b0, tex_rsp_ready;
   logic [127:0] tex_rsp_texels = '0;
   logic [46:0]  tex_rsp_tag = '0;
   logic         commit_valid, commit_ready = 1'b1;
   logic [43:0]  commit_uuid;
   logic [1:0]   commit_wid;
   logic [3:0]   commit_tmask;
   logic [31:0]  commit_pc;
   logic [4:0]   commit_rd;
   logic [127:0] commit_data;
   logic [3:0]   pending_count;

   vx_tex_agent dut (
      .clk(clk), .reset(reset),
      .exe_valid(exe_valid), .exe_uuid(exe_uuid), .exe_wid(exe_wid), .exe_tmask(exe_tmask),
      .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_coords(exe_coords), .exe_lod(exe_lod),
      .exe_stage(exe_stage), .exe_ready(exe_ready),
      .tex_req_valid(tex_req_valid), .tex_req_mask(tex_req_mask), .tex_req_coords(tex_req_coords),
      .tex_req_lod(tex_req_lod), .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
      .tex_req_ready(tex_req_ready),
      .tex_rsp_valid(tex_rsp_valid), .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
      .tex_rsp_ready(tex_rsp_ready),
      .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
      .commit_tmask(commit_tmask), .commit_pc(commit_pc), .commit_rd(commit_rd),
      .commit_data(commit_data), .commit_ready(commit_ready), .pending_count(pending_count)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // reference model: which slots are outstanding and what each one carries
   bit          mb [8];
   logic [43:0] mu [8];
   logic [1:0]  mw [8];
   logic [3:0]  mt [8];
   logic [31:0] mp [8];
   logic [4:0]  mr [8];

   logic [43:0]  nu;
   logic [1:0]   nw;
   logic [3:0]   nt;
   logic [31:0]  np;
   logic [4:0]   nr;
   logic [255:0] nco;
   logic [15:0]  nlo;
   logic [0:0]   nst;
   logic [127:0] ntx;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cnt();
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(mb[i]);
      return c;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < 8; i++) if (!mb[i]) return i;
      return 8;
   endfunction

   function automatic logic [127:0] expect_data(input logic [3:0] m, input logic [127:0] tx);
      logic [127:0] d = '0;
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = m[i] ? tx[i*32 +: 32] : 32'd0;
      return d;
   endfunction

   task automatic rnd_fields();
      nu = {12'($urandom), 32'($urandom)};
      nw = 2'($urandom);
      nt = 4'($urandom);
      np = $urandom;
      nr = 5'($urandom);
      for (int i = 0; i < 8; i++) nco[i*32 +: 32] = $urandom;
      nlo = 16'($urandom);
      nst = 1'($urandom);
      for (int i = 0; i < 4; i++) ntx[i*32 +: 32] = $urandom;
   endtask

   task automatic drive_exe();
      exe_uuid = nu; exe_wid = nw; exe_tmask = nt; exe_pc = np; exe_rd = nr;
      exe_coords = nco; exe_lod = nlo; exe_stage = nst;
   endtask

   task automatic take_slot(input int s);
      mb[s] = 1'b1; mu[s] = nu; mw[s] = nw; mt[s] = nt; mp[s] = np; mr[s] = nr;
   endtask

   // one cycle with both ready signals high: optional issue and optional response
   task automatic xfer(input bit iss, input bit rsp, input int rs);
      int es;
      es = lowest_free();
      drive_exe();
      exe_valid = iss;
      tex_rsp_valid = rsp;
      tex_rsp_tag = {mu[rs], 3'(rs)};
      tex_rsp_texels = ntx;
      tex_req_ready = 1'b1;
      commit_ready = 1'b1;
      #1;
      chk("exe_ready", exe_ready, cnt() < 8);
      chk("rsp_ready", tex_rsp_ready, 1);
      @(posedge clk); #1;
      exe_valid = 1'b0;
      tex_rsp_valid = 1'b0;
      if (iss) begin
         chk("req_valid", tex_req_valid, 1);
         chk("req_tag", tex_req_tag, {nu, 3'(es)});
         chk("req_mask", tex_req_mask, nt);
         chk("req_coords", tex_req_coords, nco);
         chk("req_lod_stage", {tex_req_lod, tex_req_stage}, {nlo, nst});
      end else chk("req_idle", tex_req_valid, 0);
      if (rsp) begin
         chk("commit_valid", commit_valid, 1);
         chk("commit_meta", {commit_uuid, commit_wid, commit_tmask, commit_pc, commit_rd},
             {mu[rs], mw[rs], mt[rs], mp[rs], mr[rs]});
         chk("commit_data", commit_data, expect_data(mt[rs], ntx));
         mb[rs] = 1'b0;
      end else chk("commit_idle", commit_valid, 0);
      if (iss) take_slot(es);
      chk("pending_count", pending_count, cnt());
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         mb[i] = 0; mu[i] = '0; mw[i] = '0; mt[i] = '0; mp[i] = '0; mr[i] = '0;
      end
      rnd_fields();
      #2;
      exe_valid = 1'b1;
      #1;
      chk("reset_exe_ready", exe_ready, 0);
      chk("reset_valids", {tex_req_valid, commit_valid}, 0);
      chk("reset_pending", pending_count, 0);
      exe_valid = 1'b0;
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // single request with the documented field values
      rnd_fields();
      nu = 44'd5; nw = 2'd2; nt = 4'b1011; nr = 5'd7;
      xfer(1, 0, 0);
      chk("t1_tag", tex_req_tag, {44'd5, 3'd0});
      chk("t1_pending1", pending_count, 1);
      ntx = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
      xfer(0, 1, 0);
      chk("t1_data", commit_data, {32'hAAAA_AAAA, 32'h0, 32'hCCCC_CCCC, 32'hDDDD_DDDD});
      chk("t1_wid_rd", {commit_wid, commit_rd}, {2'd2, 5'd7});

      // fill the table, then recycle slot 3
      for (int i = 0; i < 8; i++) begin rnd_fields(); xfer(1, 0, 0); end
      chk("t2_full_count", pending_count, 8);
      exe_valid = 1'b1;
      #1;
      chk("t2_full_ready", exe_ready, 0);
      exe_valid = 1'b0;
      @(posedge clk); #1;
      chk("t2_no_issue", tex_req_valid, 0);
      rnd_fields(); xfer(0, 1, 3);
      rnd_fields(); xfer(1, 0, 0);
      chk("t2_reuse3", tex_req_tag[2:0], 3);
      for (int s = 0; s < 8; s++) begin rnd_fields(); xfer(0, 1, s); end

      // out-of-order responses
      for (int i = 0; i < 3; i++) begin rnd_fields(); xfer(1, 0, 0); end
      rnd_fields(); xfer(0, 1, 2);
      rnd_fields(); xfer(0, 1, 0);
      rnd_fields(); xfer(0, 1, 1);

      // request-side backpressure
      rnd_fields();
      drive_exe();
      tex_req_ready = 1'b0;
      exe_valid = 1'b1;
      @(posedge clk); #1;
      exe_valid = 1'b0;
      take_slot(0);
      for (int i = 0; i < 5; i++) begin
         chk("t4_req_hold_valid", tex_req_valid, 1);
         chk("t4_req_hold_tag", tex_req_tag, {nu, 3'd0});
         chk("t4_req_hold_coords", tex_req_coords, nco);
         chk("t4_exe_blocked", exe_ready, 0);
         @(posedge clk); #1;
      end
      tex_req_ready = 1'b1;
      #1;
      chk("t4_exe_unblocked", exe_ready, 1);
      @(posedge clk); #1;
      chk("t4_req_drained", tex_req_valid, 0);

      // commit-side backpressure
      commit_ready = 1'b0;
      tex_rsp_valid = 1'b1;
      tex_rsp_tag = {mu[0], 3'd0};
      tex_rsp_texels = ntx;
      @(posedge clk); #1;
      tex_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_commit_hold", commit_valid, 1);
         chk("t4_rsp_blocked", tex_rsp_ready, 0);
         chk("t4_commit_pc_rd", {commit_pc, commit_rd}, {mp[0], mr[0]});
         chk("t4_commit_data", commit_data, expect_data(mt[0], ntx));
         @(posedge clk); #1;
      end
      commit_ready = 1'b1;
      @(posedge clk); #1;
      chk("t4_commit_drained", commit_valid, 0);
      mb[0] = 1'b0;
      chk("t4_pending", pending_count, 0);

      // alloc and free in the same cycle at full-1
      for (int i = 0; i < 7; i++) begin rnd_fields(); xfer(1, 0, 0); end
      rnd_fields(); xfer(1, 1, 0);
      chk("t5_new_slot7", tex_req_tag[2:0], 7);
      chk("t5_count7", pending_count, 7);

      // async reset mid-burst
      rnd_fields();
      drive_exe();
      tex_req_ready = 1'b0;
      commit_ready = 1'b0;
      exe_valid = 1'b1;
      tex_rsp_valid = 1'b1;
      tex_rsp_tag = {mu[1], 3'd1};
      @(posedge clk); #1;
      exe_valid = 1'b0;
      tex_rsp_valid = 1'b0;
      chk("t6_busy_before", {tex_req_valid, commit_valid}, 2'b11);
      #2 reset = 1'b1;
      #1;
      chk("t6_valids_cleared", {tex_req_valid, commit_valid}, 0);
      chk("t6_pending_cleared", pending_count, 0);
      chk("t6_exe_ready_low", exe_ready, 0);
      for (int i = 0; i < 8; i++) mb[i] = 1'b0;
      tex_req_ready = 1'b1;
      commit_ready = 1'b1;
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         bit iss, rsp;
         int rs, st;
         rnd_fields();
         iss = (cnt() < 8) && ($urandom_range(0, 1) == 1);
         rsp = (cnt() > 0) && ($urandom_range(0, 1) == 1);
         rs = 0;
         if (rsp) begin
            st = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) if (mb[(st + k) % 8]) begin rs = (st + k) % 8; break; end
         end
         xfer(iss, rsp, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
